// File: rtl/bram_sp_responder.sv
// rtl/bram_sp_responder.sv - single-port block-RAM responder with clear sequence, read latency and collision modes
module bram_sp_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W:0]   wr_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0] WR_MAX = {(ADDR_W+1){1'b1}};

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                acc;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;

  logic                p_valid_q, p_valid_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic [DATA_W-1:0]   douta_q, douta_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;

  // State register: reset restarts the clear sweep from location 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: walk the clear pointer once over the whole array, then stay ready
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_PTR) begin
        state_d = ST_READY;
      end
    end
  end

  // FSM outputs: busy flag, access acceptance and the single memory write port
  always_comb begin
    busy      = (state_q == ST_CLEAR);
    acc       = !rst && (state_q == ST_READY) && ena;
    mem_we    = !rst && ((state_q == ST_CLEAR) || (acc && wea));
    mem_waddr = (state_q == ST_CLEAR) ? ptr_q : addra;
    mem_wdata = (state_q == ST_CLEAR) ? INIT_VALUE : dina;
  end

  // Memory array; reset never writes it, only the clear sweep does
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read path: pick the word returned for this access and route it through 1 or 2 stages
  always_comb begin
    s1_data  = mem_q[addra];
    s1_valid = acc;
    if (acc && wea) begin
      if (WRITE_MODE == 1) begin
        s1_data = dina;
      end else if (WRITE_MODE == 2) begin
        s1_valid = 1'b0;
      end
    end

    p_valid_d = s1_valid;
    p_data_d  = s1_valid ? s1_data : p_data_q;

    if (READ_LATENCY == 2) begin
      out_valid = p_valid_q;
      out_data  = p_data_q;
    end else begin
      out_valid = s1_valid;
      out_data  = s1_data;
    end

    rd_valid_d = out_valid;
    douta_d    = out_valid ? out_data : douta_q;

    wr_count_d = wr_count_q;
    if (acc && wea && (wr_count_q != WR_MAX)) begin
      wr_count_d = wr_count_q + (ADDR_W+1)'(1);
    end
  end

  // Output and pipeline registers; reset flushes anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q  <= 1'b0;
      p_data_q   <= '0;
      douta_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      p_valid_q  <= p_valid_d;
      p_data_q   <= p_data_d;
      douta_q    <= douta_d;
      rd_valid_q <= rd_valid_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign douta    = douta_q;
  assign rd_valid = rd_valid_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_bram_sp_responder.sv
// tb/tb_bram_sp_responder.sv - randomized self-checking bench for bram_sp_responder
module tb_bram_sp_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        wea = 1'b0;
  logic [3:0]  addra = 4'd0;
  logic [15:0] dina = 16'd0;

  logic [15:0] douta    [3];
  logic        rd_valid [3];
  logic        busy     [3];
  logic [4:0]  wr_count [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // instance 0: latency 1 read-first, 1: latency 2 write-first, 2: latency 1 no-change
  bram_sp_responder #(.READ_LATENCY(1), .WRITE_MODE(0)) u_rf (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta[0]), .rd_valid(rd_valid[0]), .busy(busy[0]), .wr_count(wr_count[0]));
  bram_sp_responder #(.READ_LATENCY(2), .WRITE_MODE(1)) u_wf (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta[1]), .rd_valid(rd_valid[1]), .busy(busy[1]), .wr_count(wr_count[1]));
  bram_sp_responder #(.READ_LATENCY(1), .WRITE_MODE(2)) u_nc (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta[2]), .rd_valid(rd_valid[2]), .busy(busy[2]), .wr_count(wr_count[2]));

  localparam int LAT  [3] = '{1, 2, 1};
  localparam int MODE [3] = '{0, 1, 2};

  // reference model state
  int          cyc = 0;
  int          clear_left = 0;
  bit          started = 1'b0;
  logic [15:0] mem_m [16];
  int          wr_m = 0;
  logic [15:0] exp_d [3];
  bit          exp_v [3];
  bit          whv [3][4];
  logic [15:0] whd [3][4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // model: each response is scheduled on a timing wheel at (edge + latency - 1)
  always @(posedge clk) begin
    logic [15:0] old;
    int slot;
    cyc++;
    if (rst) begin
      started = 1'b1;
      clear_left = 16;
      wr_m = 0;
      for (int i = 0; i < 3; i++) begin
        exp_d[i] = 16'h0000;
        exp_v[i] = 1'b0;
        for (int s = 0; s < 4; s++) whv[i][s] = 1'b0;
      end
    end else begin
      if (clear_left > 0) begin
        mem_m[16 - clear_left] = 16'h0000;
        clear_left--;
      end else if (ena) begin
        old = mem_m[addra];
        for (int i = 0; i < 3; i++) begin
          if (!(wea && MODE[i] == 2)) begin
            slot = (cyc + LAT[i] - 1) % 4;
            whv[i][slot] = 1'b1;
            whd[i][slot] = (wea && MODE[i] == 1) ? dina : old;
          end
        end
        if (wea) begin
          mem_m[addra] = dina;
          if (wr_m < 31) wr_m++;
        end
      end
      for (int i = 0; i < 3; i++) begin
        slot = cyc % 4;
        if (whv[i][slot]) begin
          exp_d[i] = whd[i][slot];
          exp_v[i] = 1'b1;
          whv[i][slot] = 1'b0;
        end else begin
          exp_v[i] = 1'b0;
        end
      end
    end
  end

  // compare every output of every instance against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(clear_left > 0));
        check($sformatf("wr_count[%0d]", i), 32'(wr_count[i]), 32'(wr_m));
        check($sformatf("rd_valid[%0d]", i), 32'(rd_valid[i]), 32'(exp_v[i]));
        check($sformatf("douta[%0d]", i), 32'(douta[i]), 32'(exp_d[i]));
      end
    end
  end

  task automatic cycle(input bit e, input bit w, input logic [3:0] a, input logic [15:0] d);
    ena = e;
    wea = w;
    addra = a;
    dina = d;
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy[0] && n < 100) begin
      cycle(1'b0, 1'b0, 4'd0, 16'd0);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(busy[0]), 32'd0);
  endtask

  initial begin
    int n;
    @(negedge clk);

    // reset then idle
    rst = 1'b1;
    cycle(1'b0, 1'b0, 4'd0, 16'd0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0);
    rst = 1'b0;
    check("rst_douta", 32'(douta[0]), 32'h0);
    check("rst_wr_count", 32'(wr_count[0]), 32'h0);
    check("rst_busy", 32'(busy[0]), 32'h1);
    wait_ready(n);
    check("clear_len", 32'(n), 32'd16);

    // write/read sweep
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 4'(i), 16'((1 << (i + 1)) - 1));
    check("sweep_wr_count", 32'(wr_count[0]), 32'd15);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b0, 4'(i), 16'd0);
      check("sweep_rd_data", 32'(douta[0]), 32'((1 << (i + 1)) - 1));
      check("sweep_rd_valid", 32'(rd_valid[0]), 32'h1);
    end
    cycle(1'b0, 1'b0, 4'd0, 16'd0);
    check("sweep_lat2_last", 32'(douta[1]), 32'h7FFF);
    check("sweep_lat2_valid", 32'(rd_valid[1]), 32'h1);
    check("sweep_lat1_idle", 32'(rd_valid[0]), 32'h0);

    // collision modes
    cycle(1'b1, 1'b1, 4'd3, 16'hAAAA);
    cycle(1'b1, 1'b0, 4'd3, 16'd0);
    cycle(1'b1, 1'b1, 4'd3, 16'h5555);
    check("coll_read_first", 32'(douta[0]), 32'hAAAA);
    check("coll_no_change_d", 32'(douta[2]), 32'hAAAA);
    check("coll_no_change_v", 32'(rd_valid[2]), 32'h0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0);
    check("coll_write_first", 32'(douta[1]), 32'h5555);

    // saturation
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b1, 4'($urandom_range(15)), 16'($urandom));
    check("sat_wr_count", 32'(wr_count[0]), 32'd31);
    cycle(1'b1, 1'b1, 4'd1, 16'h1111);
    check("sat_hold", 32'(wr_count[0]), 32'd31);

    // access during clear is ignored
    rst = 1'b1;
    cycle(1'b0, 1'b0, 4'd0, 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 4'd5, 16'hFFFF);
    check("clear_wr_count", 32'(wr_count[0]), 32'h0);
    wait_ready(n);
    cycle(1'b1, 1'b0, 4'd5, 16'd0);
    check("clear_addr5", 32'(douta[0]), 32'h0);
    check("clear_addr5_v", 32'(rd_valid[0]), 32'h1);
    check("clear_wr_count2", 32'(wr_count[0]), 32'h0);

    // mid-stream reset discards an in-flight latency-2 read
    cycle(1'b1, 1'b1, 4'd7, 16'hBEEF);
    cycle(1'b1, 1'b0, 4'd7, 16'd0);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 4'd0, 16'd0);
    check("midrst_no_valid", 32'(rd_valid[1]), 32'h0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 4'd0, 16'd0);
    check("midrst_no_valid2", 32'(rd_valid[1]), 32'h0);
    wait_ready(n);
    check("midrst_clear_len", 32'(n), 32'd15);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 4'(i), 16'd0);
      check("midrst_init", 32'(douta[0]), 32'h0);
    end

    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(299) == 0);
      cycle($urandom_range(3) != 0, 1'($urandom_range(1)), 4'($urandom_range(15)), 16'($urandom));
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 4'd0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_sp_responder.md
Name: bram_sp_responder

Overview:
- Single-port synchronous block-RAM responder: the memory-side end of the ena/wea/addra/dina/douta interface driven by the lab memory write/read controllers.
- Replaces the vendor IP in simulation and on board. Adds a deterministic power-up/reset clear sequence, configurable read latency and collision mode.
- Reports busy and read-valid status so controllers can handshake instead of counting blind.

Parameters:
- ADDR_W, 4: address width; depth = 2**ADDR_W words.
- DATA_W, 16: word width.
- READ_LATENCY, 1: cycles from an accepted read to douta update; legal values are 1 or 2.
- WRITE_MODE, 0: 0 = READ_FIRST (douta returns old word on write), 1 = WRITE_FIRST (douta returns new word), 2 = NO_CHANGE (douta holds on write).
- INIT_VALUE, 16'h0000: word written to every location during the clear sequence.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  port enable; access accepted only when ena=1 and busy=0.
- wea  input  1  write enable, qualified by ena.
- addra  input  ADDR_W  word address.
- dina  input  DATA_W  write data.
- douta  output  DATA_W  read data, registered.
- rd_valid  output  1  one-cycle pulse, aligned with douta update from an accepted access.
- busy  output  1  clear sequence in progress; accesses are ignored.
- wr_count  output  ADDR_W+1  saturating count of accepted writes since reset.

Behaviour:
- Reset (rst=1 at posedge): douta=0, rd_valid=0, busy=1, wr_count=0, internal read pipeline flushed, clear pointer=0, FSM enters CLEAR. Memory contents are not touched in the reset cycle itself.
- FSM states and transitions:
  - CLEAR: each cycle write INIT_VALUE to mem[ptr], then ptr+1. After writing the last location (ptr = 2**ADDR_W-1), go to READY on the next cycle. Takes exactly 2**ADDR_W cycles; busy=1 throughout.
  - READY: busy=0. Remains in READY until rst.
- The first posedge with busy=0 follows 2**ADDR_W+1 posedges after rst deasserts. For the defaults that is 16 clear cycles.
- Accepted access = READY and ena=1.
  - ena=1 during CLEAR: fully ignored. No write, no rd_valid, no wr_count change.
- Write (accepted, wea=1): mem[addra] <= dina at the posedge. wr_count increments and saturates at 2**ADDR_W+... max (all ones); it does not wrap.
- Read (accepted, wea=0): data of mem[addra] appears on douta READY_LATENCY posedges later, with rd_valid=1 for that cycle.
  - Latency 1: sampled at edge N, visible after edge N.
  - Latency 2: one extra output register stage.
- Write data on douta:
  - READ_FIRST and WRITE_FIRST: an accepted write also produces douta/rd_valid at the same latency as a read.
  - NO_CHANGE: a write leaves douta unchanged and rd_valid=0.
- Back-to-back accesses are accepted every cycle; the pipeline is fully streaming.
  - Write to A at N, then read A at N+1: returns the new data in all modes.
- ena=0 or no access: douta holds its last value; rd_valid=0.
- Address is always in range, since ADDR_W covers the depth. No wrap logic is required beyond natural width.
- Reset mid-operation, in CLEAR or READY:
  - In-flight reads are discarded; no rd_valid is issued for them.
  - CLEAR restarts from ptr=0 and all contents return to INIT_VALUE.
- rst has priority over every other input.

Test Plan:
- Reset then idle: rst high 2 cycles, release → busy=1 for exactly 16 cycles, then 0. douta=0, wr_count=0, rd_valid never pulses.
- Write/read sweep: write mem[i]=(1<<(i+1))-1 for i=0..14, then read 0..14 → douta 16'h0001, 16'h0003 … 16'h7FFF. rd_valid pulses one cycle after each read with READ_LATENCY=1 and two cycles after with READ_LATENCY=2. wr_count=15.
- Collision modes: mem[3]=16'hAAAA, then write 16'h5555 to addr 3.
  - READ_FIRST → douta=16'hAAAA.
  - WRITE_FIRST → douta=16'h5555.
  - NO_CHANGE → douta unchanged, rd_valid=0.
- Access during CLEAR: ena=1, wea=1, addra=5, dina=16'hFFFF while busy=1. After READY, read addr 5 → douta=16'h0000, wr_count=0.
- Mid-stream reset: READ_LATENCY=2, issue read, then assert rst on the next cycle → no rd_valid. busy re-asserts for 16 cycles and all locations read back INIT_VALUE.
- Saturation: 40 accepted writes → wr_count=31 and holds at 31 (ADDR_W=4).
